// File: rtl/dvi_pkg.sv
// Shared constants and helpers for the DVI TMDS encoder: control tokens,
// clock-channel pattern and symbol width.
package dvi_pkg;

  localparam int SYM_W    = 10;
  localparam int PIPE_LAT = 2;

  localparam logic [SYM_W-1:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_TOK_11 = 10'b1010101011;
  localparam logic [SYM_W-1:0] CLK_PATTERN = 10'b0000011111;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [SYM_W-1:0] ctrl_token(input logic [1:0] c);
    logic [SYM_W-1:0] t;
    case (c)
      2'b00:   t = CTRL_TOK_00;
      2'b01:   t = CTRL_TOK_01;
      2'b10:   t = CTRL_TOK_10;
      2'b11:   t = CTRL_TOK_11;
      default: t = CTRL_TOK_00;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_encoder_dvi.sv
// Single TMDS channel: stage 1 transition minimisation, stage 2 DC balancing
// with a per-channel running disparity, or control token during blanking.
module tmds_encoder_dvi
  import dvi_pkg::*;
(
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             de,
  input  logic [7:0]       data_in,
  input  logic [1:0]       ctrl_in,
  output logic [SYM_W-1:0] tmds_out
);

  logic [8:0]        qm_d, qm_q;
  logic              de_q;
  logic [1:0]        ctrl_q;
  logic [SYM_W-1:0]  sym_d, sym_q;
  logic signed [5:0] cnt_d, cnt_q;

  logic [3:0]        n1d, n1q, n0q;
  logic              use_xnor;
  logic signed [5:0] diff;
  logic              q8;

  // Stage 1: choose XOR or XNOR chain to minimise transitions
  always_comb begin
    n1d      = popcount8(data_in);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && (data_in[0] == 1'b0));
    qm_d     = 9'd0;
    qm_d[0]  = data_in[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor) begin
        qm_d[i] = ~(qm_d[i-1] ^ data_in[i]);
      end else begin
        qm_d[i] = qm_d[i-1] ^ data_in[i];
      end
    end
    qm_d[8] = ~use_xnor;
  end

  // Stage 2: DC balancing; diff is ones minus zeros of q_m[7:0]
  always_comb begin
    q8    = qm_q[8];
    n1q   = popcount8(qm_q[7:0]);
    n0q   = 4'd8 - n1q;
    diff  = $signed({2'b00, n1q}) - $signed({2'b00, n0q});
    sym_d = ctrl_token(ctrl_q);
    cnt_d = 6'sd0;
    if (!de_q) begin
      sym_d = ctrl_token(ctrl_q);
      cnt_d = 6'sd0;
    end else if ((cnt_q == 6'sd0) || (n1q == n0q)) begin
      sym_d = {~q8, q8, (q8 ? qm_q[7:0] : ~qm_q[7:0])};
      cnt_d = q8 ? (cnt_q + diff) : (cnt_q - diff);
    end else if (((cnt_q > 6'sd0) && (n1q > n0q)) || ((cnt_q < 6'sd0) && (n0q > n1q))) begin
      sym_d = {1'b1, q8, ~qm_q[7:0]};
      cnt_d = cnt_q + $signed({4'b0000, q8, 1'b0}) - diff;
    end else begin
      sym_d = {1'b0, q8, qm_q[7:0]};
      cnt_d = cnt_q + diff - $signed({4'b0000, ~q8, 1'b0});
    end
  end

  // Pipeline registers for both stages
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      qm_q   <= 9'd0;
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
      sym_q  <= CTRL_TOK_00;
      cnt_q  <= 6'sd0;
    end else begin
      qm_q   <= qm_d;
      de_q   <= de;
      ctrl_q <= ctrl_in;
      sym_q  <= sym_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tmds_out = sym_q;

endmodule

// File: rtl/dvi_tmds_encode_3ch.sv
// Three-channel DVI TMDS encoder plus the fixed clock-channel symbol,
// two-cycle latency in the pixel clock domain.
module dvi_tmds_encode_3ch #(
  parameter logic [9:0] CLK_PATTERN = dvi_pkg::CLK_PATTERN
) (
  input  logic       clk_pix,
  input  logic       rst_n,
  input  logic       de,
  input  logic [7:0] data_in_ch0,
  input  logic [7:0] data_in_ch1,
  input  logic [7:0] data_in_ch2,
  input  logic [1:0] ctrl_in_ch0,
  input  logic [1:0] ctrl_in_ch1,
  input  logic [1:0] ctrl_in_ch2,
  output logic [9:0] tmds_ch0,
  output logic [9:0] tmds_ch1,
  output logic [9:0] tmds_ch2,
  output logic [9:0] tmds_clk
);

  logic [9:0] tmds_clk_d, tmds_clk_q;

  tmds_encoder_dvi u_enc_ch0 (
    .clk_pix (clk_pix), .rst_n (rst_n), .de (de),
    .data_in (data_in_ch0), .ctrl_in (ctrl_in_ch0), .tmds_out (tmds_ch0)
  );

  tmds_encoder_dvi u_enc_ch1 (
    .clk_pix (clk_pix), .rst_n (rst_n), .de (de),
    .data_in (data_in_ch1), .ctrl_in (ctrl_in_ch1), .tmds_out (tmds_ch1)
  );

  tmds_encoder_dvi u_enc_ch2 (
    .clk_pix (clk_pix), .rst_n (rst_n), .de (de),
    .data_in (data_in_ch2), .ctrl_in (ctrl_in_ch2), .tmds_out (tmds_ch2)
  );

  // Clock channel repeats the same symbol every pixel
  always_comb begin
    tmds_clk_d = CLK_PATTERN;
  end

  // Clock-channel output register
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      tmds_clk_q <= CLK_PATTERN;
    end else begin
      tmds_clk_q <= tmds_clk_d;
    end
  end

  assign tmds_clk = tmds_clk_q;

endmodule

// File: tb/tb_dvi_tmds_encode_3ch.sv
// Self-checking bench: directed steps plus random vectors against an integer
// reference model of the DVI 1.0 encoding rules.
module tb_dvi_tmds_encode_3ch;

  logic       clk_pix = 1'b0;
  logic       rst_n   = 1'b0;
  logic       de      = 1'b0;
  logic [7:0] d0 = 8'd0, d1 = 8'd0, d2 = 8'd0;
  logic [1:0] c0 = 2'd0, c1 = 2'd0, c2 = 2'd0;
  logic [9:0] t0, t1, t2, tclk;

  int total = 0;
  int bad   = 0;
  int ref_cnt [3];
  int run_disp [3];
  int nstep = 0;

  typedef struct {
    logic [2:0][9:0] e;
    logic            de;
    int              idx;
  } exp_t;

  exp_t       expq [$];
  logic [9:0] obs [3][256];

  always #5 clk_pix = ~clk_pix;

  dvi_tmds_encode_3ch dut (
    .clk_pix (clk_pix), .rst_n (rst_n), .de (de),
    .data_in_ch0 (d0), .data_in_ch1 (d1), .data_in_ch2 (d2),
    .ctrl_in_ch0 (c0), .ctrl_in_ch1 (c1), .ctrl_in_ch2 (c2),
    .tmds_ch0 (t0), .tmds_ch1 (t1), .tmds_ch2 (t2), .tmds_clk (tclk)
  );

  task automatic chk(input string tag, input logic [9:0] o, input logic [9:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [9:0] ref_enc(input int ch, input logic [7:0] d,
                                         input logic dd, input logic [1:0] c);
    int n1, n1q, n0q, q8;
    logic [7:0] qm;
    logic xn;
    logic q8b;
    if (!dd) begin
      ref_cnt[ch] = 0;
      case (c)
        2'd0:    return 10'h354;
        2'd1:    return 10'h0AB;
        2'd2:    return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    q8  = xn ? 0 : 1;
    q8b = ~xn;
    n1q = $countones(qm);
    n0q = 8 - n1q;
    if (ref_cnt[ch] == 0 || n1q == n0q) begin
      ref_cnt[ch] += (q8 == 1) ? (n1q - n0q) : (n0q - n1q);
      return {~q8b, q8b, (q8b ? qm : ~qm)};
    end else if ((ref_cnt[ch] > 0 && n1q > n0q) || (ref_cnt[ch] < 0 && n0q > n1q)) begin
      ref_cnt[ch] += 2 * q8 + n0q - n1q;
      return {1'b1, q8b, ~qm};
    end else begin
      ref_cnt[ch] += n1q - n0q - 2 * (1 - q8);
      return {1'b0, q8b, qm};
    end
  endfunction

  task automatic step(input logic sde, input logic [7:0] a0, a1, a2,
                      input logic [1:0] b0, b1, b2);
    exp_t e;
    exp_t p;
    logic [9:0] ov [3];
    de = sde; d0 = a0; d1 = a1; d2 = a2; c0 = b0; c1 = b1; c2 = b2;
    e.e[0] = ref_enc(0, a0, sde, b0);
    e.e[1] = ref_enc(1, a1, sde, b1);
    e.e[2] = ref_enc(2, a2, sde, b2);
    e.de   = sde;
    e.idx  = nstep;
    nstep++;
    expq.push_back(e);
    @(posedge clk_pix); #1;
    p = expq.pop_front();
    ov[0] = t0; ov[1] = t1; ov[2] = t2;
    chk("stream_ch0", t0, p.e[0]);
    chk("stream_ch1", t1, p.e[1]);
    chk("stream_ch2", t2, p.e[2]);
    chk("stream_clk", tclk, 10'h01F);
    for (int k = 0; k < 3; k++) begin
      if (p.idx >= 0) obs[k][p.idx & 255] = ov[k];
      if (p.de) begin
        run_disp[k] += 2 * $countones(ov[k]) - 10;
        total++;
        assert (run_disp[k] >= -10 && run_disp[k] <= 10) else begin
          bad++;
          $error("FAIL disparity_bound ch%0d observed=%0d expected=within+-10", k, run_disp[k]);
        end
      end else begin
        run_disp[k] = 0;
      end
    end
  endtask

  task automatic resync();
    exp_t p;
    de = 1'b0; c0 = 2'd0; c1 = 2'd0; c2 = 2'd0;
    @(negedge clk_pix); rst_n = 1'b1;
    @(posedge clk_pix); #1;
    expq.delete();
    p.e[0] = 10'h354; p.e[1] = 10'h354; p.e[2] = 10'h354;
    p.de = 1'b0; p.idx = -1;
    expq.push_back(p);
    for (int k = 0; k < 3; k++) begin
      ref_cnt[k]  = 0;
      run_disp[k] = 0;
    end
  endtask

  initial begin
    int base;
    logic rde;

    // Reset held across clock edges
    repeat (3) @(posedge clk_pix);
    #1;
    chk("reset_ch0", t0, 10'h354);
    chk("reset_ch1", t1, 10'h354);
    chk("reset_ch2", t2, 10'h354);
    chk("reset_clk", tclk, 10'h01F);
    resync();

    // Control tokens on ch0
    base = nstep;
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00);
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'b10, 2'b00, 2'b00);
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00);
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    chk("ctrl_00", obs[0][base],     10'h354);
    chk("ctrl_01", obs[0][base + 1], 10'h0AB);
    chk("ctrl_10", obs[0][base + 2], 10'h154);
    chk("ctrl_11", obs[0][base + 3], 10'h2AB);
    chk("ctrl_ch1", obs[1][base + 1], 10'h354);
    chk("ctrl_ch2", obs[2][base + 3], 10'h354);

    // DC balance with all-zero data, then disparity restart after blanking
    base = nstep;
    repeat (4) step(1'b1, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    step(1'b1, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) begin
      chk("dc_sym0", obs[k][base],     10'h100);
      chk("dc_sym1", obs[k][base + 1], 10'h3FF);
      chk("dc_sym2", obs[k][base + 2], 10'h100);
      chk("dc_sym3", obs[k][base + 3], 10'h3FF);
    end
    chk("restart_ch0", obs[0][base + 5], 10'h100);

    // Single-cycle de pulse amid blanking
    base = nstep;
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    step(1'b1, 8'hFF, 8'hFF, 8'hFF, 2'b00, 2'b00, 2'b00);
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    chk("pulse_before", obs[0][base],     10'h354);
    chk("pulse_data",   obs[0][base + 1], 10'h200);
    chk("pulse_after",  obs[0][base + 2], 10'h354);

    // Asynchronous reset in the middle of active video
    step(1'b1, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    step(1'b1, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    step(1'b1, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ch0", t0, 10'h354);
    chk("async_rst_ch1", t1, 10'h354);
    chk("async_rst_ch2", t2, 10'h354);
    chk("async_rst_clk", tclk, 10'h01F);
    @(posedge clk_pix);
    resync();

    // Random data/de/ctrl stream
    for (int n = 0; n < 20000; n++) begin
      rde = ($urandom_range(0, 7) != 0);
      step(rde, 8'($urandom), 8'($urandom), 8'($urandom),
           2'($urandom), 2'($urandom), 2'($urandom));
    end
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
